// File: rtl/wb_pkg.sv
// Shared definitions for the M->W pipeline register: default widths, the legal
// stage range, and the packed payload carried by every stage.
package wb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int CNT_W_DEF  = 16;
  localparam int STAGES_DEF = 1;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;

  // Payload fields are sized for the widest supported bus; narrower
  // instances zero-extend on entry and slice on exit.
  localparam int PAYLOAD_DATA_W = 64;
  localparam int PAYLOAD_ADDR_W = 8;

  typedef struct packed {
    logic                      valid;
    logic                      reg_write;
    logic                      mem_to_reg;
    logic [PAYLOAD_DATA_W-1:0] read_data;
    logic [PAYLOAD_DATA_W-1:0] alu_out;
    logic [PAYLOAD_ADDR_W-1:0] write_reg;
  } wb_stage_t;

  function automatic logic stages_legal(input int n);
    return (n >= STAGES_MIN) && (n <= STAGES_MAX);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous active-low clear.
module sat_counter
  import wb_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/wb_pipe_reg.sv
// Configurable-depth M->W pipeline register with stall/flush, zero-register
// write suppression and saturating retire/bubble performance counters.
module wb_pipe_reg
  import wb_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STAGES     = STAGES_DEF,
  parameter int ZERO_GUARD = 1,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_m,
  input  logic              reg_write_m,
  input  logic              mem_to_reg_m,
  input  logic [DATA_W-1:0] read_data_m,
  input  logic [DATA_W-1:0] alu_out_m,
  input  logic [ADDR_W-1:0] write_reg_m,
  input  logic              stall_w,
  input  logic              flush_w,
  output logic              valid_w,
  output logic              reg_write_w,
  output logic              mem_to_reg_w,
  output logic [DATA_W-1:0] read_data_w,
  output logic [DATA_W-1:0] alu_out_w,
  output logic [ADDR_W-1:0] write_reg_w,
  output logic [DATA_W-1:0] result_w,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  if (!stages_legal(STAGES) || (DATA_W > PAYLOAD_DATA_W) || (ADDR_W > PAYLOAD_ADDR_W)) begin : g_bad_params
    $error("wb_pipe_reg: unsupported parameter combination");
  end

  logic      zero_dest;
  logic      advance;
  logic      retire_inc;
  logic      bubble_inc;
  wb_stage_t entry;
  wb_stage_t stage_src [STAGES];
  wb_stage_t stage_d   [STAGES];
  wb_stage_t stage_q   [STAGES];

  assign zero_dest = (ZERO_GUARD != 0) && (write_reg_m == '0);
  assign advance   = !stall_w && !flush_w;

  // An empty slot or a write to the hard-wired zero register must never write back.
  always_comb begin
    entry            = '0;
    entry.valid      = valid_m;
    entry.reg_write  = valid_m && reg_write_m && !zero_dest;
    entry.mem_to_reg = mem_to_reg_m;
    entry.read_data  = PAYLOAD_DATA_W'(read_data_m);
    entry.alu_out    = PAYLOAD_DATA_W'(alu_out_m);
    entry.write_reg  = PAYLOAD_ADDR_W'(write_reg_m);
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign stage_src[k] = entry;
    end else begin : g_link
      assign stage_src[k] = stage_q[k-1];
    end

    // Flush beats stall; reset beats both in the flop below.
    always_comb begin
      stage_d[k] = stage_src[k];
      if (flush_w) begin
        stage_d[k] = '0;
      end else if (stall_w) begin
        stage_d[k] = stage_q[k];
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        stage_q[k] <= '0;
      end else begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign valid_w      = stage_q[STAGES-1].valid;
  assign reg_write_w  = stage_q[STAGES-1].reg_write;
  assign mem_to_reg_w = stage_q[STAGES-1].mem_to_reg;
  assign read_data_w  = stage_q[STAGES-1].read_data[DATA_W-1:0];
  assign alu_out_w    = stage_q[STAGES-1].alu_out[DATA_W-1:0];
  assign write_reg_w  = stage_q[STAGES-1].write_reg[ADDR_W-1:0];
  assign result_w     = mem_to_reg_w ? read_data_w : alu_out_w;

  // Counters judge the entry leaving the last stage on this edge.
  assign retire_inc = advance && valid_w && reg_write_w;
  assign bubble_inc = advance && !valid_w;

  sat_counter #(
    .W(CNT_W)
  ) u_retire_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (retire_inc),
    .count(retire_cnt)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_bubble_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (bubble_inc),
    .count(bubble_cnt)
  );

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Bench for wb_pipe_reg: a 1-stage/16-bit-counter and a 3-stage/4-bit-counter
// instance share one input stream and are compared with a delay-line model.
module tb_wb_pipe_reg;

  localparam int A_DEPTH = 1;
  localparam int B_DEPTH = 3;
  localparam int A_MAX   = 65535;
  localparam int B_MAX   = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        valid_m, reg_write_m, mem_to_reg_m, stall_w, flush_w;
  logic [31:0] read_data_m, alu_out_m;
  logic [4:0]  write_reg_m;

  logic        a_valid_w, a_reg_write_w, a_mem_to_reg_w;
  logic [31:0] a_read_data_w, a_alu_out_w, a_result_w;
  logic [4:0]  a_write_reg_w;
  logic [15:0] a_retire_cnt, a_bubble_cnt;

  logic        b_valid_w, b_reg_write_w, b_mem_to_reg_w;
  logic [31:0] b_read_data_w, b_alu_out_w, b_result_w;
  logic [4:0]  b_write_reg_w;
  logic [3:0]  b_retire_cnt, b_bubble_cnt;

  wb_pipe_reg #(.STAGES(A_DEPTH)) u_dut_a (
    .clk(clk), .reset(reset), .valid_m(valid_m), .reg_write_m(reg_write_m),
    .mem_to_reg_m(mem_to_reg_m), .read_data_m(read_data_m), .alu_out_m(alu_out_m),
    .write_reg_m(write_reg_m), .stall_w(stall_w), .flush_w(flush_w),
    .valid_w(a_valid_w), .reg_write_w(a_reg_write_w), .mem_to_reg_w(a_mem_to_reg_w),
    .read_data_w(a_read_data_w), .alu_out_w(a_alu_out_w), .write_reg_w(a_write_reg_w),
    .result_w(a_result_w), .retire_cnt(a_retire_cnt), .bubble_cnt(a_bubble_cnt)
  );

  wb_pipe_reg #(.STAGES(B_DEPTH), .CNT_W(4)) u_dut_b (
    .clk(clk), .reset(reset), .valid_m(valid_m), .reg_write_m(reg_write_m),
    .mem_to_reg_m(mem_to_reg_m), .read_data_m(read_data_m), .alu_out_m(alu_out_m),
    .write_reg_m(write_reg_m), .stall_w(stall_w), .flush_w(flush_w),
    .valid_w(b_valid_w), .reg_write_w(b_reg_write_w), .mem_to_reg_w(b_mem_to_reg_w),
    .read_data_w(b_read_data_w), .alu_out_w(b_alu_out_w), .write_reg_w(b_write_reg_w),
    .result_w(b_result_w), .retire_cnt(b_retire_cnt), .bubble_cnt(b_bubble_cnt)
  );

  typedef struct {
    logic        valid;
    logic        rw;
    logic        m2r;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
  } ent_t;

  // Each queue holds the last DEPTH accepted entries; the front is what W shows.
  ent_t qa[$];
  ent_t qb[$];
  int   ra, ba, rb, bb;
  int   checks = 0;
  int   errors = 0;
  int   saved;

  function automatic ent_t bubble();
    ent_t e;
    e.valid = 1'b0; e.rw = 1'b0; e.m2r = 1'b0;
    e.rd = '0; e.alu = '0; e.wr = '0;
    return e;
  endfunction

  task automatic refill();
    qa.delete();
    qb.delete();
    for (int i = 0; i < A_DEPTH; i++) qa.push_back(bubble());
    for (int i = 0; i < B_DEPTH; i++) qb.push_back(bubble());
  endtask

  task automatic model_edge();
    ent_t e;
    e.valid = valid_m;
    e.rw    = valid_m && reg_write_m && (write_reg_m != 5'd0);
    e.m2r   = mem_to_reg_m;
    e.rd    = read_data_m;
    e.alu   = alu_out_m;
    e.wr    = write_reg_m;
    if (!reset) begin
      refill();
      ra = 0; ba = 0; rb = 0; bb = 0;
    end else if (flush_w) begin
      refill();
    end else if (!stall_w) begin
      if (qa[0].valid && qa[0].rw && ra < A_MAX) ra++;
      if (!qa[0].valid && ba < A_MAX) ba++;
      if (qb[0].valid && qb[0].rw && rb < B_MAX) rb++;
      if (!qb[0].valid && bb < B_MAX) bb++;
      qa.push_back(e);
      void'(qa.pop_front());
      qb.push_back(e);
      void'(qb.pop_front());
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " a.valid"},  32'(a_valid_w),      32'(qa[0].valid));
    chk({tag, " a.rw"},     32'(a_reg_write_w),  32'(qa[0].rw));
    chk({tag, " a.m2r"},    32'(a_mem_to_reg_w), 32'(qa[0].m2r));
    chk({tag, " a.rd"},     a_read_data_w,       qa[0].rd);
    chk({tag, " a.alu"},    a_alu_out_w,         qa[0].alu);
    chk({tag, " a.wr"},     32'(a_write_reg_w),  32'(qa[0].wr));
    chk({tag, " a.result"}, a_result_w,          qa[0].m2r ? qa[0].rd : qa[0].alu);
    chk({tag, " a.retire"}, 32'(a_retire_cnt),   ra);
    chk({tag, " a.bubble"}, 32'(a_bubble_cnt),   ba);
    chk({tag, " b.valid"},  32'(b_valid_w),      32'(qb[0].valid));
    chk({tag, " b.rw"},     32'(b_reg_write_w),  32'(qb[0].rw));
    chk({tag, " b.m2r"},    32'(b_mem_to_reg_w), 32'(qb[0].m2r));
    chk({tag, " b.rd"},     b_read_data_w,       qb[0].rd);
    chk({tag, " b.alu"},    b_alu_out_w,         qb[0].alu);
    chk({tag, " b.wr"},     32'(b_write_reg_w),  32'(qb[0].wr));
    chk({tag, " b.result"}, b_result_w,          qb[0].m2r ? qb[0].rd : qb[0].alu);
    chk({tag, " b.retire"}, 32'(b_retire_cnt),   rb);
    chk({tag, " b.bubble"}, 32'(b_bubble_cnt),   bb);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic set_idle();
    valid_m = 1'b0; reg_write_m = 1'b0; mem_to_reg_m = 1'b0;
    read_data_m = '0; alu_out_m = '0; write_reg_m = '0;
    stall_w = 1'b0; flush_w = 1'b0;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r,
                       input logic [31:0] rd, input logic [31:0] alu, input logic [4:0] wr);
    valid_m = v; reg_write_m = rw; mem_to_reg_m = m2r;
    read_data_m = rd; alu_out_m = alu; write_reg_m = wr;
  endtask

  initial begin
    reset = 1'b0;
    set_idle();
    refill();
    ra = 0; ba = 0; rb = 0; bb = 0;

    tick("reset0");
    tick("reset1");
    chk("reset a.valid", 32'(a_valid_w), 32'd0);
    chk("reset b.retire", 32'(b_retire_cnt), 32'd0);

    // Single write through the 1-stage instance.
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, $urandom, 32'h0000_00AA, 5'd3);
    tick("basic");
    chk("basic a.rw", 32'(a_reg_write_w), 32'd1);
    chk("basic a.wr", 32'(a_write_reg_w), 32'd3);
    chk("basic a.result", a_result_w, 32'h0000_00AA);

    // Four loads through the 3-stage instance from a clean start.
    reset = 1'b0;
    set_idle();
    tick("pre-stream reset");
    reset = 1'b1;
    for (int j = 0; j < 7; j++) begin
      if (j < 4) drive(1'b1, 1'b1, 1'b1, 32'(j + 1), $urandom, 5'($urandom_range(1, 31)));
      else set_idle();
      tick("stream");
      if (j < 4) chk("stream a.rd", a_read_data_w, 32'(j + 1));
      if (j >= 2 && j <= 5) begin
        chk("latency3 b.rd", b_read_data_w, 32'(j - 1));
        chk("latency3 b.valid", 32'(b_valid_w), 32'd1);
      end
    end
    chk("drained b.retire", 32'(b_retire_cnt), 32'd4);

    // Stall one cycle, then flush while still stalled.
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 1'b1, 1'($urandom), $urandom, $urandom, 5'($urandom_range(1, 31)));
      tick("fill");
    end
    stall_w = 1'b1;
    drive(1'b1, 1'b1, 1'b1, $urandom, $urandom, 5'd7);
    tick("stall");
    saved = rb;
    flush_w = 1'b1;
    tick("stall+flush");
    chk("flush b.valid", 32'(b_valid_w), 32'd0);
    chk("flush b.rw", 32'(b_reg_write_w), 32'd0);
    chk("flush b.alu", b_alu_out_w, 32'd0);
    chk("flush b.wr", 32'(b_write_reg_w), 32'd0);
    chk("flush a.rd", a_read_data_w, 32'd0);
    chk("flush b.retire held", 32'(b_retire_cnt), saved);

    // Write aimed at register 0 must be suppressed but its data kept.
    set_idle();
    drive(1'b1, 1'b1, 1'b0, $urandom, 32'h1234_5678, 5'd0);
    tick("zero-guard");
    chk("zero-guard a.rw", 32'(a_reg_write_w), 32'd0);
    chk("zero-guard a.alu", a_alu_out_w, 32'h1234_5678);
    chk("zero-guard a.valid", 32'(a_valid_w), 32'd1);
    saved = ra;
    set_idle();
    tick("zero-guard drain");
    chk("zero-guard a.retire held", 32'(a_retire_cnt), saved);

    // Random traffic with occasional stall and flush.
    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom),
            $urandom, $urandom, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom));
      stall_w = ($urandom_range(0, 4) == 0);
      flush_w = ($urandom_range(0, 19) == 0);
      tick("random");
    end

    // Idle run: the 4-bit bubble counter must pin at 15.
    reset = 1'b0;
    set_idle();
    tick("sat reset");
    reset = 1'b1;
    for (int n = 0; n < 20; n++) tick("idle");
    chk("sat b.bubble", 32'(b_bubble_cnt), 32'hF);
    chk("sat a.bubble", 32'(a_bubble_cnt), 32'd20);

    // Reset during a stall discards in-flight entries without retiring them.
    drive(1'b1, 1'b1, 1'b0, $urandom, $urandom, 5'd9);
    tick("inflight1");
    drive(1'b1, 1'b1, 1'b1, $urandom, $urandom, 5'd10);
    tick("inflight2");
    stall_w = 1'b1;
    reset = 1'b0;
    tick("mid reset");
    chk("mid reset b.valid", 32'(b_valid_w), 32'd0);
    chk("mid reset b.bubble", 32'(b_bubble_cnt), 32'd0);
    chk("mid reset a.retire", 32'(a_retire_cnt), 32'd0);
    reset = 1'b1;
    set_idle();
    for (int n = 0; n < 4; n++) tick("post reset");
    chk("post reset b.retire", 32'(b_retire_cnt), 32'd0);
    chk("post reset a.retire", 32'(a_retire_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_pipe_reg.md
WB_PIPE_REG -- requirements
Module: wb_pipe_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of read-data, ALU-result and result buses.
REQ-002 SHALL have parameter ADDR_W, default 5, destination-register index width.
REQ-003 SHALL have parameter STAGES, default 1, legal 1..4, number of register stages between M and W.
REQ-004 SHALL have parameter ZERO_GUARD, default 1, when 1 suppresses writes to register index 0.
REQ-005 SHALL have parameter CNT_W, default 16, width of the performance counters.
REQ-006 SHALL have ports in this order: clk input 1 (clock); reset input 1 (synchronous, active-low).
REQ-007 SHALL have these M-side inputs:
- valid_m, 1, instruction present.
- reg_write_m, 1, register write enable.
- mem_to_reg_m, 1, result-select.
- read_data_m, DATA_W, memory data.
- alu_out_m, DATA_W, ALU result.
- write_reg_m, ADDR_W, destination index.
REQ-008 SHALL have these control inputs, 1 bit each: stall_w (hold all stages) and flush_w (kill all stages).
REQ-009 SHALL have these W-side outputs, all registered:
- valid_w, 1.
- reg_write_w, 1.
- mem_to_reg_w, 1.
- read_data_w, DATA_W.
- alu_out_w, DATA_W.
- write_reg_w, ADDR_W.
REQ-010 SHALL have output result_w, DATA_W, combinational: read_data_w when mem_to_reg_w=1, else alu_out_w.
REQ-011 SHALL have outputs retire_cnt and bubble_cnt, CNT_W each.

Function
REQ-012 Stage k SHALL load stage k-1 (stage 0 loads the M inputs) on each clk edge where reset=1, stall_w=0 and flush_w=0; latency M->W SHALL be exactly STAGES cycles.
REQ-013 With stall_w=1 and flush_w=0, every stage and both counters SHALL hold their values.
REQ-014 With flush_w=1, every stage SHALL clear: valid, reg_write, mem_to_reg to 0 and data/address fields to 0; flush SHALL win over a simultaneous stall.
REQ-015 On entry to stage 0, reg_write SHALL be the AND of valid_m and reg_write_m, so an invalid slot never writes.
REQ-016 When ZERO_GUARD=1 and write_reg_m=0, reg_write SHALL enter stage 0 as 0; the data fields SHALL still be captured.
REQ-017 On any advancing edge (no stall, no flush) where the last stage has valid=1 and reg_write=1, retire_cnt SHALL increment.
REQ-018 On any advancing edge where the last stage has valid=0, bubble_cnt SHALL increment.
REQ-019 Both counters SHALL saturate at all-ones and never wrap.
REQ-020 A flush SHALL NOT change either counter.
REQ-021 The last stage's fields SHALL drive the *_w outputs directly, with no extra register.

Reset
REQ-022 While reset=0 at a clk edge, all outputs and counters SHALL clear:
- all stages: valid, reg_write, mem_to_reg = 0; data and address fields = 0.
- retire_cnt, bubble_cnt = 0.
Reset SHALL override stall_w and flush_w.
REQ-023 Asserting reset mid-stream SHALL discard all in-flight entries; the first capture after release SHALL occur on the first edge with reset=1.

Structure
REQ-024 The default widths, the STAGES legal range and a packed stage-payload struct (valid, reg_write, mem_to_reg, read_data, alu_out, write_reg) SHALL reside in shared package wb_pkg.
REQ-025 The saturating counter SHALL be a sub-module named sat_counter, instantiated twice.
REQ-026 The stage chain SHALL be a generate loop over STAGES, with no behavioural differences between stages.

Verification
REQ-027 STAGES=1: drive valid_m=1, reg_write_m=1, write_reg_m=5'd3, alu_out_m=32'h0000_00AA, mem_to_reg_m=0. Required: one cycle later reg_write_w=1, write_reg_w=3, result_w=32'h0000_00AA.
REQ-028 STAGES=3: drive a stream of 4 values (1, 2, 3, 4) with mem_to_reg_m=1. Required: each read_data_w appears exactly 3 cycles after input, and retire_cnt=4 after draining.
REQ-029 Hold stall_w=1 for 2 cycles mid-stream, with flush_w=1 on the second stalled cycle. Required: outputs frozen during the first stall cycle, then valid_w=0, reg_write_w=0, all fields 0, and counters unchanged.
REQ-030 ZERO_GUARD=1: drive write_reg_m=0 with reg_write_m=1, valid_m=1, alu_out_m=32'h1234_5678. Required: reg_write_w=0, alu_out_w=32'h1234_5678, retire_cnt unchanged.
REQ-031 CNT_W=4: drive 20 idle advancing cycles. Required: bubble_cnt stops at 4'hF.
REQ-032 Drive reset=0 for one edge with 2 valid entries in flight and stall_w=1. Required: all outputs and counters 0 next cycle, and no retire occurs for the discarded entries.
